eq_coe_loader: RTL and testbench

EQ_COE_LOADER -- requirements
Module: eq_coe_loader

---
 rtl/eq_coe_loader.sv | 136 +++++++++++++
 tb/tb_eq_coe_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coe_loader.sv
// Coefficient table and serial load sequencer for the equalizer.
// Optional readback port: define EQ_COE_LOADER_READBACK_EN.
module eq_coe_loader #(
    parameter  int COE_WIDTH     = 16,
    parameter  int INV_COE_WIDTH = 8,
    parameter  int COE_NUM       = 17,
    parameter  int GAP           = 0,
    localparam int FW            = COE_WIDTH + INV_COE_WIDTH,
    localparam int AW            = $clog2(COE_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [FW-1:0] i_wr_data,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_load_coe,
    output logic [FW-1:0] o_coedata,
    output logic          o_busy,
    output logic          o_done
`ifdef EQ_COE_LOADER_READBACK_EN
    ,
    input  logic [AW-1:0] i_rd_addr,
    output logic [FW-1:0] o_rd_data
`endif
);

    localparam logic [AW:0]   NUM    = (AW+1)'(COE_NUM);
    localparam logic [AW-1:0] LAST   = AW'(COE_NUM - 1);
    localparam logic [7:0]    GAP_M1 = 8'(GAP - 1);
    localparam logic [FW-1:0] IDENT  = FW'((1 << (FW - 3)) - 1);
    localparam bit            NO_GAP = (GAP == 0);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FLUSH} state_t;

    state_t        state;
    logic [FW-1:0] tbl [COE_NUM];
    logic [AW-1:0] idx;
    logic [7:0]    gcnt;
    logic          wr_ok;
    logic [FW-1:0] first_word;

    assign wr_ok = i_wr_en && ({1'b0, i_wr_addr} < NUM) && !o_busy;

    // A write to the last tap in the start cycle must reach the first pulse.
    assign first_word = (wr_ok && i_wr_addr == LAST) ? i_wr_data : tbl[LAST];

    // Coefficient table: identity on reset, writes only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COE_NUM; i++)
                tbl[i] <= (i == COE_NUM / 2) ? IDENT : '0;
        end else if (wr_ok) begin
            tbl[i_wr_addr] <= i_wr_data;
        end
    end

    // Load sequencer: last tap first, GAP idle cycles between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            gcnt       <= '0;
            o_load_coe <= 1'b0;
            o_coedata  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_load_coe <= 1'b0;
            o_coedata  <= '0;
            o_done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start && !i_abort && !o_done) begin
                        state      <= SEND;
                        idx        <= LAST;
                        o_load_coe <= 1'b1;
                        o_coedata  <= first_word;
                        o_busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (idx == '0) begin
                        state <= FLUSH;
                    end else if (NO_GAP) begin
                        idx        <= idx - 1'b1;
                        o_load_coe <= 1'b1;
                        o_coedata  <= tbl[idx - 1'b1];
                    end else begin
                        state <= WAIT;
                        gcnt  <= GAP_M1;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (gcnt == '0) begin
                        state      <= SEND;
                        idx        <= idx - 1'b1;
                        o_load_coe <= 1'b1;
                        o_coedata  <= tbl[idx - 1'b1];
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                FLUSH: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= !i_abort;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef EQ_COE_LOADER_READBACK_EN
    // Registered table readback, zero for addresses past the last tap.
    always_ff @(posedge clk) begin
        if (reset)
            o_rd_data <= '0;
        else if ({1'b0, i_rd_addr} < NUM)
            o_rd_data <= tbl[i_rd_addr];
        else
            o_rd_data <= '0;
    end
`endif

endmodule

// File: tb/tb_eq_coe_loader.sv
// Bench for eq_coe_loader: GAP=0 and GAP=2 instances against a
// schedule-based reference model.
module tb_eq_coe_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  wr_en = '0;
    logic [4:0]  wr_addr [2];
    logic [23:0] wr_data [2];
    logic [1:0]  start = '0;
    logic [1:0]  abort = '0;
    logic [1:0]  load;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [23:0] coed [2];
`ifdef EQ_COE_LOADER_READBACK_EN
    logic [4:0]  rd_addr [2];
    logic [23:0] rd_data [2];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eq_coe_loader #(.GAP(0)) u0 (
        .clk(clk), .reset(reset),
        .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]),
        .i_start(start[0]), .i_abort(abort[0]),
        .o_load_coe(load[0]), .o_coedata(coed[0]),
        .o_busy(busy[0]), .o_done(done[0])
`ifdef EQ_COE_LOADER_READBACK_EN
        , .i_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0])
`endif
    );

    eq_coe_loader #(.GAP(2)) u2 (
        .clk(clk), .reset(reset),
        .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]),
        .i_start(start[1]), .i_abort(abort[1]),
        .o_load_coe(load[1]), .o_coedata(coed[1]),
        .o_busy(busy[1]), .o_done(done[1])
`ifdef EQ_COE_LOADER_READBACK_EN
        , .i_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1])
`endif
    );

    // Reference model: table contents plus position within a sequence.
    logic [23:0] mtbl [2][17];
    bit          act [2];
    int          rel [2];

    function automatic int per(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic void get_exp(input int d, output logic b,
                                    output logic l, output logic [23:0] dat,
                                    output logic dn);
        int p;
        int lr;
        b = 1'b0; l = 1'b0; dat = '0; dn = 1'b0;
        if (act[d]) begin
            p  = per(d);
            lr = 16 * p;
            if (rel[d] <= lr) begin
                b = 1'b1;
                if (rel[d] % p == 0) begin
                    l   = 1'b1;
                    dat = mtbl[d][16 - rel[d] / p];
                end
            end else if (rel[d] == lr + 1) begin
                b = 1'b1;
            end else begin
                dn = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        b, l, dn;
            logic [23:0] dat;
            int          lr;
            if (reset) begin
                for (int i = 0; i < 17; i++)
                    mtbl[d][i] = (i == 8) ? 24'h1FFFFF : 24'h0;
                act[d] = 1'b0;
                rel[d] = 0;
            end else begin
                get_exp(d, b, l, dat, dn);
                if (wr_en[d] && wr_addr[d] < 5'd17 && !b)
                    mtbl[d][wr_addr[d]] = wr_data[d];
                lr = 16 * per(d);
                if (act[d]) begin
                    if (abort[d] && rel[d] <= lr + 1) act[d] = 1'b0;
                    else if (rel[d] == lr + 2) act[d] = 1'b0;
                    else rel[d] = rel[d] + 1;
                end else if (start[d] && !abort[d]) begin
                    act[d] = 1'b1;
                    rel[d] = 0;
                end
            end
        end
    end

    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    int          ndone0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic        b, l, dn;
            logic [23:0] dat;
            get_exp(d, b, l, dat, dn);
            chk($sformatf("load%0d", d), 32'(load[d]), 32'(l));
            chk($sformatf("data%0d", d), 32'(coed[d]), 32'(dat));
            chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(b));
            chk($sformatf("done%0d", d), 32'(done[d]), 32'(dn));
        end
        if (load[0] === 1'b1) q0.push_back(coed[0]);
        if (load[1] === 1'b1) q1.push_back(coed[1]);
        if (done[0] === 1'b1) ndone0++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic wait_pulses(input int target);
        int i;
        for (i = 0; i < 200; i++) begin
            if (q0.size() >= target) break;
            cyc(1);
        end
        chk("wait_pulses", 32'(q0.size() >= target), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_addr[d] = '0;
            wr_data[d] = '0;
`ifdef EQ_COE_LOADER_READBACK_EN
            rd_addr[d] = '0;
`endif
        end

        // Reset state
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Identity table on both instances
        q0.delete(); q1.delete(); ndone0 = 0;
        start = 2'b11;
        cyc(1);
        start = 2'b00;
        cyc(60);
        chk("id_count0", 32'(q0.size()), 32'd17);
        chk("id_tap8", 32'(q0[8]), 32'h1FFFFF);
        chk("id_tap0", 32'(q0[16]), 32'h0);
        chk("id_count2", 32'(q1.size()), 32'd17);
        chk("id_done0", 32'(ndone0), 32'd1);

        // Table load: ramp on GAP=2, random on GAP=0
        for (int k = 0; k < 17; k++) begin
            wr_en = 2'b11;
            wr_addr[0] = 5'(k); wr_addr[1] = 5'(k);
            wr_data[0] = 24'($urandom);
            wr_data[1] = 24'(k + 1);
            cyc(1);
        end
        wr_en = 2'b00;
        cyc(1);

        // Same-cycle write of the last tap with start
        q0.delete(); q1.delete();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd16; wr_data[0] = 24'hA5C3E1;
        start = 2'b11;
        cyc(1);
        wr_en = 2'b00; start = 2'b00;
        chk("same_cycle_wr", 32'(q0[0]), 32'hA5C3E1);

        // Writes during busy are dropped
        cyc(4);
        wr_en = 2'b11;
        wr_addr[0] = 5'd3; wr_addr[1] = 5'd3;
        wr_data[0] = 24'($urandom); wr_data[1] = 24'h777777;
        cyc(1);
        wr_en = 2'b00;
        cyc(60);
        chk("ramp_count", 32'(q1.size()), 32'd17);
        for (int i = 0; i < 17 && i < q1.size(); i++)
            chk($sformatf("ramp%0d", i), 32'(q1[i]), 32'(17 - i));

        // Out-of-range write in idle is dropped
        wr_en = 2'b11;
        wr_addr[0] = 5'd20; wr_addr[1] = 5'd20;
        wr_data[0] = 24'hFFFFFF; wr_data[1] = 24'hFFFFFF;
        cyc(1);
        wr_en = 2'b00;
        q1.delete();
        start[1] = 1'b1;
        cyc(1);
        start[1] = 1'b0;
        cyc(55);
        chk("tap3_kept", 32'(q1[13]), 32'd4);

        // Abort after the 5th pulse
        q0.delete(); ndone0 = 0;
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        wait_pulses(5);
        abort[0] = 1'b1;
        cyc(1);
        abort[0] = 1'b0;
        cyc(25);
        chk("abort_pulses", 32'(q0.size()), 32'd5);
        chk("abort_nodone", 32'(ndone0), 32'd0);
        q0.delete();
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        cyc(22);
        chk("restart_pulses", 32'(q0.size()), 32'd17);

        // Start held high: back-to-back sequences every 20 cycles
        q0.delete(); ndone0 = 0;
        start[0] = 1'b1;
        cyc(60);
        start[0] = 1'b0;
        cyc(25);
        chk("held_done", 32'(ndone0), 32'd3);
        chk("held_pulses", 32'(q0.size()), 32'd51);

        // Start and abort together in idle
        q0.delete();
        start[0] = 1'b1; abort[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0; abort[0] = 1'b0;
        cyc(5);
        chk("start_abort", 32'(q0.size()), 32'd0);

        // Random writes, starts and aborts
        for (int r = 0; r < 6; r++) begin
            wr_en = 2'b11;
            wr_addr[0] = 5'($urandom_range(0, 20));
            wr_addr[1] = 5'($urandom_range(0, 20));
            wr_data[0] = 24'($urandom); wr_data[1] = 24'($urandom);
            start = 2'b11;
            cyc(1);
            wr_en = 2'b00; start = 2'b00;
            cyc($urandom_range(1, 40));
            abort = 2'($urandom_range(0, 3));
            cyc(1);
            abort = 2'b00;
            cyc(60);
        end

        // Reset at the 10th pulse restores identity
        q0.delete();
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        wait_pulses(10);
        reset = 1'b1;
        cyc(1);
        chk("rst_load", 32'(load[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        cyc(1);
        reset = 1'b0;
        q0.delete();
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        cyc(22);
        chk("rst_id_count", 32'(q0.size()), 32'd17);
        chk("rst_id_tap8", 32'(q0[8]), 32'h1FFFFF);
        chk("rst_id_tap16", 32'(q0[0]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
